// File: rtl/alu_execute_stage.sv
// Execute stage: single-cycle ALU/compare/LUI path plus an iterative 32-cycle
// multiply/divide unit with HI/LO registers and an issue stall for dependent MD ops.
module alu_execute_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  mode,
    input  logic [4:0]  reg_address,
    input  logic [4:0]  add_mem,
    input  logic        cal,
    input  logic        load,
    input  logic        store,
    input  logic        write_reg,
    input  logic        jump,
    input  logic        enable,
    input  logic        cmp,
    input  logic        cmp_signed,
    input  logic        lui,
    input  logic [31:0] cal_A,
    input  logic [31:0] cal_B,
    input  logic [31:0] mem_data,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] out_result,
    output logic [4:0]  out_reg_address,
    output logic [4:0]  out_add_mem,
    output logic        out_write_reg,
    output logic        out_load,
    output logic        out_store,
    output logic        out_jump,
    output logic [31:0] out_mem_data,
    output logic        md_busy
);

    localparam logic [4:0] ModeAdd   = 5'd0;
    localparam logic [4:0] ModeSub   = 5'd1;
    localparam logic [4:0] ModeAnd   = 5'd2;
    localparam logic [4:0] ModeOr    = 5'd3;
    localparam logic [4:0] ModeXor   = 5'd4;
    localparam logic [4:0] ModeNor   = 5'd5;
    localparam logic [4:0] ModeSll   = 5'd6;
    localparam logic [4:0] ModeSrl   = 5'd7;
    localparam logic [4:0] ModeSra   = 5'd8;
    localparam logic [4:0] ModeMult  = 5'd9;
    localparam logic [4:0] ModeMultu = 5'd10;
    localparam logic [4:0] ModeDiv   = 5'd11;
    localparam logic [4:0] ModeDivu  = 5'd12;
    localparam logic [4:0] ModeMfhi  = 5'd13;
    localparam logic [4:0] ModeMflo  = 5'd14;

    typedef enum logic {StIdle, StBusy} md_state_e;

    md_state_e   state_q;
    logic [4:0]  count_q;
    logic [31:0] mcand_q;
    logic [31:0] work_hi_q;
    logic [31:0] work_lo_q;
    logic        is_div_q;
    logic        neg_q;
    logic        neg_rem_q;
    logic        div_zero_q;
    logic [31:0] dividend_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        unused_cal;
    assign unused_cal = cal;

    // Decode: lui and cmp take priority over mode, so they never count as MD ops.
    logic is_md_op;
    logic is_md_any;
    logic accept;
    logic md_start;
    logic signed_op;

    assign is_md_op  = !lui && !cmp && (mode >= ModeMult) && (mode <= ModeDivu);
    assign is_md_any = !lui && !cmp && (mode >= ModeMult) && (mode <= ModeMflo);
    assign stall     = reset && (state_q == StBusy) && enable && is_md_any;
    assign accept    = enable && !stall;
    assign md_start  = accept && is_md_op && (state_q == StIdle);
    assign signed_op = (mode == ModeMult) || (mode == ModeDiv);
    assign md_busy   = (state_q == StBusy);

    logic [31:0] a_mag;
    logic [31:0] b_mag;

    assign a_mag = (signed_op && cal_A[31]) ? (32'd0 - cal_A) : cal_A;
    assign b_mag = (signed_op && cal_B[31]) ? (32'd0 - cal_B) : cal_B;

    // Single-cycle result path.
    logic [31:0] alu_result;
    logic [4:0]  shamt;

    assign shamt = cal_A[4:0];

    always_comb begin
        alu_result = 32'd0;
        if (lui) begin
            alu_result = {cal_B[15:0], 16'h0000};
        end else if (cmp) begin
            if (cmp_signed) begin
                alu_result = ($signed(cal_A) < $signed(cal_B)) ? 32'd1 : 32'd0;
            end else begin
                alu_result = (cal_A < cal_B) ? 32'd1 : 32'd0;
            end
        end else if (load || store) begin
            alu_result = cal_A + cal_B;
        end else begin
            case (mode)
                ModeAdd:  alu_result = cal_A + cal_B;
                ModeSub:  alu_result = cal_A - cal_B;
                ModeAnd:  alu_result = cal_A & cal_B;
                ModeOr:   alu_result = cal_A | cal_B;
                ModeXor:  alu_result = cal_A ^ cal_B;
                ModeNor:  alu_result = ~(cal_A | cal_B);
                ModeSll:  alu_result = cal_B << shamt;
                ModeSrl:  alu_result = cal_B >> shamt;
                ModeSra:  alu_result = $signed(cal_B) >>> shamt;
                ModeMfhi: alu_result = hi_q;
                ModeMflo: alu_result = lo_q;
                default:  alu_result = 32'd0;
            endcase
        end
    end

    // One MD iteration: shift-add multiply (LSB first) or restoring divide (MSB first).
    logic [32:0] sum33;
    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic [31:0] iter_hi;
    logic [31:0] iter_lo;

    always_comb begin
        sum33     = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, mcand_q} : 33'd0);
        rem_shift = {work_hi_q, work_lo_q[31]};
        diff      = rem_shift - {1'b0, mcand_q};
        iter_hi   = 32'd0;
        iter_lo   = 32'd0;
        if (is_div_q) begin
            if (!diff[32]) begin
                iter_hi = diff[31:0];
                iter_lo = {work_lo_q[30:0], 1'b1};
            end else begin
                iter_hi = rem_shift[31:0];
                iter_lo = {work_lo_q[30:0], 1'b0};
            end
        end else begin
            iter_hi = sum33[32:1];
            iter_lo = {sum33[0], work_lo_q[31:1]};
        end
    end

    // Sign fix-up and divide-by-zero override applied to the last iteration.
    logic [63:0] prod;
    logic [31:0] fin_hi;
    logic [31:0] fin_lo;

    always_comb begin
        prod   = {iter_hi, iter_lo};
        fin_hi = 32'd0;
        fin_lo = 32'd0;
        if (is_div_q) begin
            if (div_zero_q) begin
                fin_lo = 32'hFFFF_FFFF;
                fin_hi = dividend_q;
            end else begin
                fin_lo = neg_q ? (32'd0 - iter_lo) : iter_lo;
                fin_hi = neg_rem_q ? (32'd0 - iter_hi) : iter_hi;
            end
        end else begin
            if (neg_q) begin
                prod = 64'd0 - prod;
            end
            fin_hi = prod[63:32];
            fin_lo = prod[31:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            count_q    <= 5'd0;
            mcand_q    <= 32'd0;
            work_hi_q  <= 32'd0;
            work_lo_q  <= 32'd0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            dividend_q <= 32'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (md_start) begin
                        state_q    <= StBusy;
                        count_q    <= 5'd0;
                        mcand_q    <= b_mag;
                        work_hi_q  <= 32'd0;
                        work_lo_q  <= a_mag;
                        is_div_q   <= (mode == ModeDiv) || (mode == ModeDivu);
                        neg_q      <= signed_op && (cal_A[31] ^ cal_B[31]);
                        neg_rem_q  <= signed_op && cal_A[31];
                        div_zero_q <= (cal_B == 32'd0);
                        dividend_q <= cal_A;
                    end
                end
                StBusy: begin
                    work_hi_q <= iter_hi;
                    work_lo_q <= iter_lo;
                    count_q   <= count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        hi_q    <= fin_hi;
                        lo_q    <= fin_lo;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Sideband data is captured every cycle; only the qualifier bits mark a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid       <= 1'b0;
            out_result      <= 32'd0;
            out_reg_address <= 5'd0;
            out_add_mem     <= 5'd0;
            out_write_reg   <= 1'b0;
            out_load        <= 1'b0;
            out_store       <= 1'b0;
            out_jump        <= 1'b0;
            out_mem_data    <= 32'd0;
        end else begin
            out_result      <= alu_result;
            out_reg_address <= reg_address;
            out_add_mem     <= add_mem;
            out_mem_data    <= mem_data;
            out_valid       <= accept;
            out_write_reg   <= accept && write_reg && !is_md_op;
            out_load        <= accept && load;
            out_store       <= accept && store;
            out_jump        <= accept && jump;
        end
    end

endmodule

// File: tb/tb_alu_execute_stage.sv
// Randomized self-checking bench for alu_execute_stage against a plain-arithmetic model.
module tb_alu_execute_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  mode, reg_address, add_mem;
    logic        cal, load, store, write_reg, jump, enable, cmp, cmp_signed, lui;
    logic [31:0] cal_A, cal_B, mem_data;
    logic        stall, out_valid, out_write_reg, out_load, out_store, out_jump, md_busy;
    logic [31:0] out_result, out_mem_data;
    logic [4:0]  out_reg_address, out_add_mem;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    alu_execute_stage dut (
        .clk(clk), .reset(reset), .mode(mode), .reg_address(reg_address),
        .add_mem(add_mem), .cal(cal), .load(load), .store(store),
        .write_reg(write_reg), .jump(jump), .enable(enable), .cmp(cmp),
        .cmp_signed(cmp_signed), .lui(lui), .cal_A(cal_A), .cal_B(cal_B),
        .mem_data(mem_data), .stall(stall), .out_valid(out_valid),
        .out_result(out_result), .out_reg_address(out_reg_address),
        .out_add_mem(out_add_mem), .out_write_reg(out_write_reg),
        .out_load(out_load), .out_store(out_store), .out_jump(out_jump),
        .out_mem_data(out_mem_data), .md_busy(md_busy)
    );

    function automatic logic [31:0] ref_result(input logic [4:0] m, input logic [31:0] a,
                                               input logic [31:0] b, input logic c,
                                               input logic cs, input logic l,
                                               input logic [31:0] hi, input logic [31:0] lo);
        int sa, sb;
        sa = a;
        sb = b;
        if (l) return {b[15:0], 16'h0000};
        if (c) return cs ? ((sa < sb) ? 32'd1 : 32'd0) : ((a < b) ? 32'd1 : 32'd0);
        case (m)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ~(a | b);
            6: return b << a[4:0];
            7: return b >> a[4:0];
            8: return sb >>> a[4:0];
            13: return hi;
            14: return lo;
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_md(input logic [4:0] m, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
        longint sp;
        logic [63:0] up;
        int sa, sb;
        sa = a;
        sb = b;
        hi = 32'd0;
        lo = 32'd0;
        if (m == 9) begin
            sp = longint'(sa) * longint'(sb);
            hi = sp[63:32];
            lo = sp[31:0];
        end else if (m == 10) begin
            up = {32'd0, a} * {32'd0, b};
            hi = up[63:32];
            lo = up[31:0];
        end else if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (m == 11) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                lo = 32'h8000_0000;
                hi = 32'd0;
            end else begin
                lo = sa / sb;
                hi = sa % sb;
            end
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mode = 5'd0; reg_address = 5'd0; add_mem = 5'd0; cal = 1'b0; load = 1'b0;
        store = 1'b0; write_reg = 1'b0; jump = 1'b0; enable = 1'b0; cmp = 1'b0;
        cmp_signed = 1'b0; lui = 1'b0; cal_A = 32'd0; cal_B = 32'd0; mem_data = 32'd0;
    endtask

    task automatic set_op(input logic [4:0] m, input logic [31:0] a, input logic [31:0] b);
        clear_inputs();
        mode = m;
        cal_A = a;
        cal_B = b;
        cal = 1'b1;
        enable = 1'b1;
    endtask

    // Issue an MD op and wait (bounded) for the unit to go idle.
    task automatic do_md(input logic [4:0] m, input logic [31:0] a, input logic [31:0] b,
                         output int cycles);
        set_op(m, a, b);
        tick();
        clear_inputs();
        cycles = 0;
        while (md_busy && cycles < 100) begin
            tick();
            cycles++;
        end
        ref_md(m, a, b, m_hi, m_lo);
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        set_op(5'd13, 32'd0, 32'd0);
        tick();
        hi = out_result;
        set_op(5'd14, 32'd0, 32'd0);
        tick();
        lo = out_result;
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        set_op(5'd13, 32'd0, 32'd0);
        #2;
        n_checks++;
        if ({out_valid, out_result, out_write_reg, out_load, out_store, out_jump,
             out_reg_address, out_add_mem, out_mem_data, md_busy, stall} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b result=%h busy=%b stall=%b, required all 0",
                     out_valid, out_result, md_busy, stall);
        end
        @(negedge clk);
        reset = 1'b1;
        set_op(5'd0, 32'd10, 32'd20);
        write_reg = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd30) begin
            n_fail++;
            $display("FAIL first_after_reset: got valid=%b result=%h, required 1 0000001e",
                     out_valid, out_result);
        end
        clear_inputs();
    endtask

    task automatic test_add_wrap();
        set_op(5'd0, 32'hFFFF_FFFF, 32'd1);
        write_reg = 1'b1;
        reg_address = 5'd5;
        tick();
        n_checks++;
        if ({out_result, out_valid, out_reg_address, out_write_reg} !==
            {32'd0, 1'b1, 5'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL add_wrap: got result=%h valid=%b ra=%0d wr=%b, required 0 1 5 1",
                     out_result, out_valid, out_reg_address, out_write_reg);
        end
        clear_inputs();
    endtask

    task automatic test_cmp_lui();
        set_op(5'd1, 32'hFFFF_FFFF, 32'd1);
        cmp = 1'b1;
        cmp_signed = 1'b1;
        tick();
        n_checks++;
        if (out_result !== 32'd1) begin
            n_fail++;
            $display("FAIL cmp_signed: got %h required 00000001", out_result);
        end
        cmp_signed = 1'b0;
        tick();
        n_checks++;
        if (out_result !== 32'd0) begin
            n_fail++;
            $display("FAIL cmp_unsigned: got %h required 00000000", out_result);
        end
        set_op(5'd3, 32'hDEAD_BEEF, 32'h0000_1234);
        lui = 1'b1;
        cmp = 1'b1;
        tick();
        n_checks++;
        if (out_result !== 32'h1234_0000) begin
            n_fail++;
            $display("FAIL lui: got %h required 12340000", out_result);
        end
        clear_inputs();
    endtask

    task automatic test_random_alu();
        logic [31:0] exp_res;
        logic [4:0]  exp_flags;
        int r;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 11);
            clear_inputs();
            mode = (r <= 8) ? r[4:0] : (r == 9) ? 5'($urandom_range(15, 31)) :
                   (r == 10) ? 5'd13 : 5'd14;
            cal_A = $urandom;
            cal_B = $urandom;
            mem_data = $urandom;
            reg_address = 5'($urandom);
            add_mem = 5'($urandom);
            write_reg = 1'($urandom);
            jump = 1'($urandom);
            enable = ($urandom_range(0, 3) != 0);
            cmp_signed = 1'($urandom);
            case ($urandom_range(0, 7))
                0: lui = 1'b1;
                1: cmp = 1'b1;
                2: begin load = 1'b1; mode = 5'd0; end
                3: begin store = 1'b1; mode = 5'd0; end
                default: ;
            endcase
            exp_res = ref_result(mode, cal_A, cal_B, cmp, cmp_signed, lui, m_hi, m_lo);
            exp_flags = enable ? {1'b1, write_reg, load, store, jump} : 5'd0;
            tick();
            n_checks++;
            if ({out_valid, out_write_reg, out_load, out_store, out_jump} !== exp_flags) begin
                n_fail++;
                $display("FAIL rand_flags[%0d]: got %b required %b", i,
                         {out_valid, out_write_reg, out_load, out_store, out_jump}, exp_flags);
            end
            if (exp_flags[4]) begin
                n_checks++;
                if ({out_result, out_reg_address, out_add_mem, out_mem_data} !==
                    {exp_res, reg_address, add_mem, mem_data}) begin
                    n_fail++;
                    $display("FAIL rand_data[%0d] mode=%0d: got %h/%0d/%0d/%h required %h/%0d/%0d/%h",
                             i, mode, out_result, out_reg_address, out_add_mem, out_mem_data,
                             exp_res, reg_address, add_mem, mem_data);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_mult_stall();
        int n_stall;
        set_op(5'd9, 32'hFFFF_FFFD, 32'd7);
        write_reg = 1'b1;
        tick();
        n_checks++;
        if ({out_valid, out_write_reg, md_busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL mult_issue: got valid/wr/busy=%b required 101",
                     {out_valid, out_write_reg, md_busy});
        end
        set_op(5'd14, 32'd0, 32'd0);
        write_reg = 1'b1;
        #1;
        n_stall = 0;
        while (stall && n_stall < 100) begin
            tick();
            n_stall++;
        end
        n_checks++;
        if (n_stall !== 32) begin
            n_fail++;
            $display("FAIL mult_stall_cycles: got %0d required 32", n_stall);
        end
        tick();
        n_checks++;
        if (out_result !== 32'hFFFF_FFEB || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mult_mflo: got %h valid=%b required ffffffeb 1", out_result, out_valid);
        end
        set_op(5'd13, 32'd0, 32'd0);
        tick();
        n_checks++;
        if (out_result !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL mult_mfhi: got %h required ffffffff", out_result);
        end
        ref_md(5'd9, 32'hFFFF_FFFD, 32'd7, m_hi, m_lo);
        clear_inputs();
    endtask

    task automatic test_md();
        logic [31:0] hi, lo, a, b;
        logic [4:0]  m;
        int cyc;
        do_md(5'd11, 32'hFFFF_FFF9, 32'd2, cyc);
        read_hilo(hi, lo);
        n_checks++;
        if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            n_fail++;
            $display("FAIL div_neg7_2: got hi=%h lo=%h required ffffffff fffffffd", hi, lo);
        end
        do_md(5'd12, 32'd5, 32'd0, cyc);
        read_hilo(hi, lo);
        n_checks++;
        if ({hi, lo} !== {32'd5, 32'hFFFF_FFFF}) begin
            n_fail++;
            $display("FAIL divu_by_zero: got hi=%h lo=%h required 00000005 ffffffff", hi, lo);
        end
        do_md(5'd11, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        read_hilo(hi, lo);
        n_checks++;
        if ({hi, lo} !== {32'd0, 32'h8000_0000}) begin
            n_fail++;
            $display("FAIL div_min_neg1: got hi=%h lo=%h required 00000000 80000000", hi, lo);
        end
        for (int i = 0; i < 16; i++) begin
            m = 5'($urandom_range(9, 12));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ?
                32'($urandom_range(1, 300)) : $urandom);
            if ($urandom_range(0, 1) == 1) a = 32'd0 - 32'($urandom_range(0, 5000));
            do_md(m, a, b, cyc);
            n_checks++;
            if (cyc !== 32) begin
                n_fail++;
                $display("FAIL md_latency[%0d]: got %0d required 32", i, cyc);
            end
            read_hilo(hi, lo);
            n_checks++;
            if ({hi, lo} !== {m_hi, m_lo}) begin
                n_fail++;
                $display("FAIL md_rand[%0d] mode=%0d a=%h b=%h: got %h_%h required %h_%h",
                         i, m, a, b, hi, lo, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, hi, lo;
        int n;
        a1 = $urandom;
        b1 = $urandom;
        a2 = $urandom;
        b2 = $urandom;
        set_op(5'd10, a1, b1);
        tick();
        set_op(5'd0, 32'd2, 32'd3);
        write_reg = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0 || md_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_add_stall: got stall=%b busy=%b required 0 1", stall, md_busy);
        end
        tick();
        n_checks++;
        if ({out_result, out_valid, out_write_reg} !== {32'd5, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL busy_add_result: got %h valid=%b wr=%b required 00000005 1 1",
                     out_result, out_valid, out_write_reg);
        end
        set_op(5'd10, a2, b2);
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_multu_stall: got %b required 1", stall);
        end
        n = 0;
        while (stall && n < 100) begin
            tick();
            n++;
        end
        n_checks++;
        if (md_busy !== 1'b0 || n !== 31) begin
            n_fail++;
            $display("FAIL stall_release: got busy=%b after %0d cycles required 0 after 31",
                     md_busy, n);
        end
        tick();
        n_checks++;
        if ({md_busy, out_valid, out_write_reg} !== 3'b110) begin
            n_fail++;
            $display("FAIL second_multu_accept: got busy/valid/wr=%b required 110",
                     {md_busy, out_valid, out_write_reg});
        end
        clear_inputs();
        n = 0;
        while (md_busy && n < 100) begin
            tick();
            n++;
        end
        ref_md(5'd10, a2, b2, m_hi, m_lo);
        read_hilo(hi, lo);
        n_checks++;
        if ({hi, lo} !== {m_hi, m_lo}) begin
            n_fail++;
            $display("FAIL second_multu_value: got %h_%h required %h_%h", hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_during_div();
        logic [31:0] hi, lo;
        set_op(5'd11, 32'd1000, 32'd7);
        tick();
        set_op(5'd14, 32'd0, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({md_busy, stall, out_valid, out_result, out_write_reg, out_load, out_store,
             out_jump} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_div: got busy=%b stall=%b valid=%b result=%h required all 0",
                     md_busy, stall, out_valid, out_result);
        end
        @(negedge clk);
        reset = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        read_hilo(hi, lo);
        n_checks++;
        if ({hi, lo} !== 64'd0) begin
            n_fail++;
            $display("FAIL hilo_after_abort: got %h_%h required 0_0", hi, lo);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_add_wrap();
        test_cmp_lui();
        test_random_alu();
        test_mult_stall();
        test_random_alu();
        test_md();
        test_back_to_back();
        test_reset_during_div();
        test_random_alu();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
